// File: rtl/tiny8_regfile_sb.sv
// tiny8_regfile_sb: parametrised register file with two write ports, NREAD
// combinational read ports, optional write-to-read bypass and a per-register
// busy scoreboard for issue-time destination reservation.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   we0/waddr0/wdata0   write port 0
//   we1/waddr1/wdata1   write port 1 (wins on same-address collision)
//   raddr               packed read addresses, port i at [i*AW +: AW]
//   rdata               packed read data, port i at [i*WIDTH +: WIDTH]
//   rbusy               per read port: addressed register still awaits writeback
//   rsv_en/rsv_addr     reserve (mark busy) a destination register
//   busy                scoreboard bit per register
//   wr_conflict         registered: both ports wrote one address last cycle
module tiny8_regfile_sb #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NREAD     = 2,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned ZERO_REG0 = 0,
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we0,
  input  logic [AW-1:0]          waddr0,
  input  logic [WIDTH-1:0]       wdata0,
  input  logic                   we1,
  input  logic [AW-1:0]          waddr1,
  input  logic [WIDTH-1:0]       wdata1,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic [DEPTH-1:0]       busy,
  output logic                   wr_conflict
);

  logic [WIDTH-1:0] regs [DEPTH];

  // One-hot write/reserve decode; register 0 is masked out when hard-wired.
  logic [DEPTH-1:0] hit0_c;
  logic [DEPTH-1:0] hit1_c;
  logic [DEPTH-1:0] rsv_hit_c;

  always_comb begin
    hit0_c            = '0;
    hit1_c            = '0;
    rsv_hit_c         = '0;
    hit0_c[waddr0]    = we0;
    hit1_c[waddr1]    = we1;
    rsv_hit_c[rsv_addr] = rsv_en;
    if (ZERO_REG0 != 0) begin
      hit0_c[0]    = 1'b0;
      hit1_c[0]    = 1'b0;
      rsv_hit_c[0] = 1'b0;
    end
  end

  // Storage, scoreboard and collision flag. Reservation beats writeback
  // clear because it names a newer producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (hit1_c[r]) begin
          regs[r] <= wdata1;
        end else if (hit0_c[r]) begin
          regs[r] <= wdata0;
        end
      end
      busy        <= rsv_hit_c | (busy & ~(hit0_c | hit1_c));
      wr_conflict <= we0 & we1 & (waddr0 == waddr1);
    end
  end

  // Combinational read ports with optional forwarding of this cycle's write.
  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] rd;
  logic             clr;

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    clr   = 1'b0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      ra  = raddr[p*AW +: AW];
      rd  = regs[ra];
      clr = hit0_c[ra] | hit1_c[ra];
      if (BYPASS != 0) begin
        if (hit1_c[ra]) begin
          rd = wdata1;
        end else if (hit0_c[ra]) begin
          rd = wdata0;
        end
      end
      rbusy[p] = busy[ra] & ~(clr & (BYPASS != 0));
      if ((ZERO_REG0 != 0) && (ra == '0)) begin
        rd       = '0;
        rbusy[p] = 1'b0;
      end
      rdata[p*WIDTH +: WIDTH] = rd;
    end
  end

endmodule

// File: tb/tb_tiny8_regfile_sb.sv
// Bench for tiny8_regfile_sb: three instances (bypass, no bypass, zero-reg
// 8x16) checked against an array-based model of register contents and busy
// flags, with directed scenarios followed by random traffic.
module tb_tiny8_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for the two 4x8 instances.
  logic        we0, we1, rsv_en;
  logic [1:0]  waddr0, waddr1, rsv_addr;
  logic [7:0]  wdata0, wdata1;
  logic [3:0]  raddr;
  logic [15:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [3:0]  busy_b, busy_n;
  logic        conf_b, conf_n;

  // Stimulus for the 8x16 zero-register instance.
  logic        zwe0, zwe1, zrsv_en;
  logic [2:0]  zwaddr0, zwaddr1, zrsv_addr;
  logic [15:0] zwdata0, zwdata1;
  logic [5:0]  zraddr;
  logic [31:0] zrdata;
  logic [1:0]  zrbusy;
  logic [7:0]  zbusy;
  logic        zconf;

  tiny8_regfile_sb #(.WIDTH(8), .DEPTH(4), .NREAD(2), .BYPASS(1), .ZERO_REG0(0)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_b), .wr_conflict(conf_b));

  tiny8_regfile_sb #(.WIDTH(8), .DEPTH(4), .NREAD(2), .BYPASS(0), .ZERO_REG0(0)) u_nob (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_n), .wr_conflict(conf_n));

  tiny8_regfile_sb #(.WIDTH(16), .DEPTH(8), .NREAD(2), .BYPASS(1), .ZERO_REG0(1)) u_zr (
    .clk(clk), .rst_n(rst_n),
    .we0(zwe0), .waddr0(zwaddr0), .wdata0(zwdata0),
    .we1(zwe1), .waddr1(zwaddr1), .wdata1(zwdata1),
    .raddr(zraddr), .rdata(zrdata), .rbusy(zrbusy),
    .rsv_en(zrsv_en), .rsv_addr(zrsv_addr), .busy(zbusy), .wr_conflict(zconf));

  // Reference model state.
  logic [7:0]  m_mem [4];
  bit          m_busy [4];
  bit          m_conf;
  logic [15:0] z_mem [8];
  bit          z_busy [8];
  bit          z_conf;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit wr_hits(logic [1:0] a);
    return (we0 && waddr0 == a) || (we1 && waddr1 == a);
  endfunction

  function automatic logic [7:0] exp_rd(bit byp, logic [1:0] a);
    if (byp && we1 && waddr1 == a) return wdata1;
    if (byp && we0 && waddr0 == a) return wdata0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rb(bit byp, logic [1:0] a);
    return m_busy[a] && !(byp && wr_hits(a));
  endfunction

  function automatic logic [15:0] exp_zrd(logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (zwe1 && zwaddr1 == a) return zwdata1;
    if (zwe0 && zwaddr0 == a) return zwdata0;
    return z_mem[a];
  endfunction

  function automatic logic exp_zrb(logic [2:0] a);
    if (a == 3'd0) return 1'b0;
    return z_busy[a] && !((zwe0 && zwaddr0 == a) || (zwe1 && zwaddr1 == a));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++) begin m_mem[r] = 8'h00; m_busy[r] = 1'b0; end
    for (int r = 0; r < 8; r++) begin z_mem[r] = 16'h0000; z_busy[r] = 1'b0; end
    m_conf = 1'b0;
    z_conf = 1'b0;
  endtask

  // Apply the rules of one clock edge to the model, using current inputs.
  task automatic model_edge();
    for (int r = 0; r < 4; r++) begin
      bit wr;
      wr = wr_hits(2'(r));
      if (we0 && waddr0 == 2'(r)) m_mem[r] = wdata0;
      if (we1 && waddr1 == 2'(r)) m_mem[r] = wdata1;
      if (rsv_en && rsv_addr == 2'(r)) m_busy[r] = 1'b1;
      else if (wr) m_busy[r] = 1'b0;
    end
    for (int r = 1; r < 8; r++) begin
      bit wr;
      wr = (zwe0 && zwaddr0 == 3'(r)) || (zwe1 && zwaddr1 == 3'(r));
      if (zwe0 && zwaddr0 == 3'(r)) z_mem[r] = zwdata0;
      if (zwe1 && zwaddr1 == 3'(r)) z_mem[r] = zwdata1;
      if (zrsv_en && zrsv_addr == 3'(r)) z_busy[r] = 1'b1;
      else if (wr) z_busy[r] = 1'b0;
    end
    m_conf = we0 && we1 && (waddr0 == waddr1);
    z_conf = zwe0 && zwe1 && (zwaddr0 == zwaddr1);
  endtask

  // Called just after a falling edge with inputs applied: compare every
  // output against the model, then take the rising edge.
  task automatic step();
    logic [3:0] mb;
    logic [7:0] zb;
    #1;
    for (int p = 0; p < 2; p++) begin
      logic [1:0] a;
      logic [2:0] za;
      a  = raddr[p*2 +: 2];
      za = zraddr[p*3 +: 3];
      check($sformatf("rdata_byp[%0d]", p), 64'(rdata_b[p*8 +: 8]), 64'(exp_rd(1'b1, a)));
      check($sformatf("rdata_nob[%0d]", p), 64'(rdata_n[p*8 +: 8]), 64'(exp_rd(1'b0, a)));
      check($sformatf("rbusy_byp[%0d]", p), 64'(rbusy_b[p]), 64'(exp_rb(1'b1, a)));
      check($sformatf("rbusy_nob[%0d]", p), 64'(rbusy_n[p]), 64'(exp_rb(1'b0, a)));
      check($sformatf("rdata_zr[%0d]", p), 64'(zrdata[p*16 +: 16]), 64'(exp_zrd(za)));
      check($sformatf("rbusy_zr[%0d]", p), 64'(zrbusy[p]), 64'(exp_zrb(za)));
    end
    for (int r = 0; r < 4; r++) mb[r] = m_busy[r];
    for (int r = 0; r < 8; r++) zb[r] = z_busy[r];
    check("busy_byp", 64'(busy_b), 64'(mb));
    check("busy_nob", 64'(busy_n), 64'(mb));
    check("busy_zr", 64'(zbusy), 64'(zb));
    check("wr_conflict_byp", 64'(conf_b), 64'(m_conf));
    check("wr_conflict_nob", 64'(conf_n), 64'(m_conf));
    check("wr_conflict_zr", 64'(zconf), 64'(z_conf));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
    zwe0 = 1'b0; zwe1 = 1'b0; zrsv_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    waddr0 = '0; waddr1 = '0; rsv_addr = '0; wdata0 = '0; wdata1 = '0; raddr = '0;
    zwaddr0 = '0; zwaddr1 = '0; zrsv_addr = '0; zwdata0 = '0; zwdata1 = '0; zraddr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset: load state, then pulse rst_n low between edges.
    we0 = 1'b1; waddr0 = 2'd2; wdata0 = 8'hA5;
    we1 = 1'b1; waddr1 = 2'd2; wdata1 = 8'hA5;
    rsv_en = 1'b1; rsv_addr = 2'd1;
    step();
    idle(); raddr = 4'b1010;
    #1;
    check("pre_reset_r2", 64'(rdata_n[7:0]), 64'h00A5);
    check("pre_reset_conf", 64'(conf_b), 64'h1);
    rst_n = 1'b0;
    #1;
    check("reset_rdata", 64'(rdata_n), 64'h0000);
    check("reset_busy", 64'(busy_b), 64'h0);
    check("reset_conf", 64'(conf_b), 64'h0);
    model_reset();
    rst_n = 1'b1;
    step();

    // Dual write to distinct addresses, then a collision on r2.
    we0 = 1'b1; waddr0 = 2'd1; wdata0 = 8'h11;
    we1 = 1'b1; waddr1 = 2'd3; wdata1 = 8'h33;
    step();
    idle(); raddr = {2'd3, 2'd1};
    #1;
    check("dual_read", 64'(rdata_n), 64'h3311);
    step();
    we0 = 1'b1; waddr0 = 2'd2; wdata0 = 8'h44;
    we1 = 1'b1; waddr1 = 2'd2; wdata1 = 8'h55;
    step();
    idle(); raddr = {2'd2, 2'd2};
    #1;
    check("collide_r2", 64'(rdata_n[7:0]), 64'h55);
    check("collide_conf_hi", 64'(conf_n), 64'h1);
    step();
    #1;
    check("collide_conf_lo", 64'(conf_n), 64'h0);
    step();

    // Bypass versus stored-only read of r0.
    we0 = 1'b1; waddr0 = 2'd0; wdata0 = 8'h7E; raddr = 4'b0000;
    #1;
    check("bypass_same_cycle", 64'(rdata_b[7:0]), 64'h7E);
    check("nobypass_same_cycle", 64'(rdata_n[7:0]), 64'h00);
    step();
    idle();
    #1;
    check("nobypass_next_cycle", 64'(rdata_n[7:0]), 64'h7E);
    step();

    // Scoreboard reserve and writeback release.
    rsv_en = 1'b1; rsv_addr = 2'd2;
    step();
    idle(); raddr = {2'd0, 2'd2};
    #1;
    check("sb_busy_set", 64'(busy_b), 64'h4);
    check("sb_rbusy_set", 64'(rbusy_b[0]), 64'h1);
    step();
    we0 = 1'b1; waddr0 = 2'd2; wdata0 = 8'h09;
    #1;
    check("sb_wb_rbusy_byp", 64'(rbusy_b[0]), 64'h0);
    check("sb_wb_rbusy_nob", 64'(rbusy_n[0]), 64'h1);
    step();
    idle();
    #1;
    check("sb_busy_clear", 64'(busy_b), 64'h0);
    step();

    // Reserve and writeback on the same register in one cycle.
    rsv_en = 1'b1; rsv_addr = 2'd1;
    step();
    rsv_en = 1'b1; rsv_addr = 2'd1; we1 = 1'b1; waddr1 = 2'd1; wdata1 = 8'h5A;
    step();
    idle(); raddr = {2'd1, 2'd1};
    #1;
    check("race_busy", 64'(busy_n[1]), 64'h1);
    check("race_data", 64'(rdata_n[7:0]), 64'h5A);
    step();

    // Hard-wired register 0 on the 8x16 instance.
    zwe0 = 1'b1; zwaddr0 = 3'd0; zwdata0 = 16'hBEEF;
    zwe1 = 1'b1; zwaddr1 = 3'd7; zwdata1 = 16'hBEEF;
    zrsv_en = 1'b1; zrsv_addr = 3'd0; zraddr = {3'd7, 3'd0};
    #1;
    check("zr_bypass_read", 64'(zrdata), 64'hBEEF_0000);
    step();
    idle();
    #1;
    check("zr_stored_read", 64'(zrdata), 64'hBEEF_0000);
    check("zr_busy0", 64'(zbusy[0]), 64'h0);
    step();

    // Random traffic on all instances.
    for (int i = 0; i < 400; i++) begin
      we0      = 1'($urandom);
      we1      = 1'($urandom);
      rsv_en   = 1'($urandom);
      waddr0   = 2'($urandom);
      waddr1   = 2'($urandom);
      rsv_addr = 2'($urandom);
      wdata0   = 8'($urandom);
      wdata1   = 8'($urandom);
      raddr    = 4'($urandom);
      zwe0      = 1'($urandom);
      zwe1      = 1'($urandom);
      zrsv_en   = 1'($urandom);
      zwaddr0   = 3'($urandom);
      zwaddr1   = 3'($urandom);
      zrsv_addr = 3'($urandom);
      zwdata0   = 16'($urandom);
      zwdata1   = 16'($urandom);
      zraddr    = 6'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
